sobel_stream_engine: RTL and testbench

- Streaming successor to the per-window Sobel controller.
- Accepts a raster-ordered grayscale frame one pixel per handshake and keeps two line buffers plus a 3x3 shift window.
- Emits one edge pixel for every interior window position, so (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame.
- Image size, pixel width and output mode are configurable; valid/ready flow control applies on both sides.

---
 rtl/sobel_stream_engine.sv | 202 ++++++++++++++++++++
 tb/tb_sobel_stream_engine.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge engine: two line buffers feed a sliding window and
// one edge pixel is emitted per interior window, with valid/ready on both sides.
module sobel_stream_engine #(
   parameter int unsigned PIXEL_W    = 8,
   parameter int unsigned IMG_WIDTH  = 160,
   parameter int unsigned IMG_HEIGHT = 120,
   parameter int unsigned COL_BITS   = $clog2(IMG_WIDTH),
   parameter int unsigned ROW_BITS   = $clog2(IMG_HEIGHT)
) (
   input  logic               clk_i,
   input  logic               nreset_i,
   input  logic               start_i,
   input  logic [1:0]         mode_i,
   input  logic [PIXEL_W-1:0] threshold_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [PIXEL_W-1:0] in_px_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [PIXEL_W-1:0] out_px_o,
   output logic               out_last_o,
   output logic               busy_o,
   output logic               frame_done_o
);

   localparam int unsigned ACC_W = PIXEL_W + 4;
   localparam int unsigned MAG_W = ACC_W + 1;
   localparam logic [PIXEL_W-1:0]  PX_MAX   = '1;
   localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_WIDTH - 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [PIXEL_W-1:0]  thr_q, thr_d;
   logic [COL_BITS-1:0] col_q, col_d;
   logic [ROW_BITS-1:0] row_q, row_d;
   logic                exh_q, exh_d;
   logic [PIXEL_W-1:0]  win_q [6];
   logic [PIXEL_W-1:0]  win_d [6];
   logic [PIXEL_W-1:0]  out_px_q, out_px_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [PIXEL_W-1:0]  lb0_q [IMG_WIDTH];
   logic [PIXEL_W-1:0]  lb1_q [IMG_WIDTH];

   logic                in_ready_c, accept_c, out_fire_c, win_ok_c;
   logic [PIXEL_W-1:0]  lb0_rd_c, lb1_rd_c, edge_px_c;
   logic [PIXEL_W-1:0]  tap_c [9];
   logic [ACC_W-1:0]    gx_c, gy_c, ax_c, ay_c;
   logic [MAG_W-1:0]    sum_c;
   logic [PIXEL_W-1:0]  sum_sat_c;

   function automatic logic [PIXEL_W-1:0] sat_px(input logic [MAG_W-1:0] v);
      return (v > MAG_W'(PX_MAX)) ? PX_MAX : v[PIXEL_W-1:0];
   endfunction

   // gx/gy are two's complement in ACC_W bits; MSB is the sign
   function automatic logic [ACC_W-1:0] abs_acc(input logic [ACC_W-1:0] v);
      return v[ACC_W-1] ? ACC_W'(~v + ACC_W'(1)) : v;
   endfunction

   assign lb0_rd_c   = lb0_q[col_q];
   assign lb1_rd_c   = lb1_q[col_q];
   assign in_ready_c = (state_q == ST_RUN) && !exh_q && (!out_valid_q || out_ready_i);
   assign accept_c   = in_valid_i && in_ready_c;
   assign out_fire_c = out_valid_q && out_ready_i;
   assign win_ok_c   = accept_c && (row_q >= ROW_BITS'(2)) && (col_q >= COL_BITS'(2));

   // Window as it will look after this accept: right column is the new one
   assign tap_c = '{win_q[0], win_q[1], lb1_rd_c,
                    win_q[2], win_q[3], lb0_rd_c,
                    win_q[4], win_q[5], in_px_i};

   always_comb begin
      gx_c = (ACC_W'(tap_c[2]) + (ACC_W'(tap_c[5]) << 1) + ACC_W'(tap_c[8]))
           - (ACC_W'(tap_c[0]) + (ACC_W'(tap_c[3]) << 1) + ACC_W'(tap_c[6]));
      gy_c = (ACC_W'(tap_c[6]) + (ACC_W'(tap_c[7]) << 1) + ACC_W'(tap_c[8]))
           - (ACC_W'(tap_c[0]) + (ACC_W'(tap_c[1]) << 1) + ACC_W'(tap_c[2]));
      ax_c      = abs_acc(gx_c);
      ay_c      = abs_acc(gy_c);
      sum_c     = MAG_W'(ax_c) + MAG_W'(ay_c);
      sum_sat_c = sat_px(sum_c);
      case (mode_q)
         2'b00:   edge_px_c = sum_sat_c;
         2'b01:   edge_px_c = (sum_sat_c >= thr_q) ? PX_MAX : '0;
         2'b10:   edge_px_c = sat_px(MAG_W'(ax_c));
         default: edge_px_c = sat_px(MAG_W'(ay_c));
      endcase
   end

   // Next-state, counters, window shift and output register
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      thr_d       = thr_q;
      col_d       = col_q;
      row_d       = row_q;
      exh_d       = exh_q;
      win_d       = win_q;
      out_px_d    = out_px_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               mode_d  = mode_i;
               thr_d   = threshold_i;
               col_d   = '0;
               row_d   = '0;
               exh_d   = 1'b0;
            end
         end
         ST_RUN:  if (out_fire_c && out_last_q) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (accept_c) begin
         win_d = '{win_q[1], lb1_rd_c, win_q[3], lb0_rd_c, win_q[5], in_px_i};
         if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
               row_d = '0;
               exh_d = 1'b1;
            end else begin
               row_d = row_q + ROW_BITS'(1);
            end
         end else begin
            col_d = col_q + COL_BITS'(1);
         end
      end

      if (win_ok_c) begin
         out_valid_d = 1'b1;
         out_px_d    = edge_px_c;
         out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end else if (out_fire_c) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q     <= ST_IDLE;
         mode_q      <= '0;
         thr_q       <= '0;
         col_q       <= '0;
         row_q       <= '0;
         exh_q       <= 1'b0;
         for (int i = 0; i < 6; i++) win_q[i] <= '0;
         out_px_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         thr_q       <= thr_d;
         col_q       <= col_d;
         row_q       <= row_d;
         exh_q       <= exh_d;
         win_q       <= win_d;
         out_px_q    <= out_px_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Line buffers hold the two previous rows; contents need no reset
   always_ff @(posedge clk_i) begin
      if (accept_c) begin
         lb1_q[col_q] <= lb0_rd_c;
         lb0_q[col_q] <= in_px_i;
      end
   end

   assign in_ready_o   = in_ready_c;
   assign out_valid_o  = out_valid_q;
   assign out_px_o     = out_px_q;
   assign out_last_o   = out_last_q;
   assign busy_o       = busy_q;
   assign frame_done_o = done_q;

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Bench for sobel_stream_engine: 4x4, 5x5 and 6x6 instances checked against a
// per-frame Sobel model of the whole image.
module tb_sobel_stream_engine;

   localparam int NDUT = 3;

   logic       clk = 1'b0;
   logic       nreset;
   logic       start     [NDUT];
   logic       in_valid  [NDUT];
   logic [1:0] mode;
   logic [7:0] thr;
   logic [7:0] in_px;
   logic       out_ready;
   logic       in_ready  [NDUT];
   logic       out_valid [NDUT];
   logic [7:0] out_px    [NDUT];
   logic       out_last  [NDUT];
   logic       busy      [NDUT];
   logic       frame_done[NDUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      sobel_stream_engine #(
         .PIXEL_W   (8),
         .IMG_WIDTH (4 + g),
         .IMG_HEIGHT(4 + g)
      ) u_dut (
         .clk_i       (clk),
         .nreset_i    (nreset),
         .start_i     (start[g]),
         .mode_i      (mode),
         .threshold_i (thr),
         .in_valid_i  (in_valid[g]),
         .in_ready_o  (in_ready[g]),
         .in_px_i     (in_px),
         .out_valid_o (out_valid[g]),
         .out_ready_i (out_ready),
         .out_px_o    (out_px[g]),
         .out_last_o  (out_last[g]),
         .busy_o      (busy[g]),
         .frame_done_o(frame_done[g])
      );
   end

   int checks    = 0;
   int failures  = 0;
   int act       = 0;
   int n_out     = 0;
   int post_last = 0;
   bit stall_mode = 1'b0;
   bit stall_done = 1'b0;
   int stall_left = 0;
   bit stalled_prev = 1'b0;
   int hold_px   = 0;
   int img [36];
   int w, h;
   int exp_px   [$];
   bit exp_last [$];

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
      end
   endtask

   function automatic int px_at(input int r, input int c);
      return img[r * w + c];
   endfunction

   // Expected output stream for the whole frame, centre by centre in raster order
   task automatic build_model(input int m, input int t);
      exp_px.delete();
      exp_last.delete();
      for (int r = 1; r <= h - 2; r++) begin
         for (int c = 1; c <= w - 2; c++) begin
            int gx, gy, ax, ay, mag, v;
            gx = (px_at(r-1, c+1) + 2 * px_at(r, c+1) + px_at(r+1, c+1))
               - (px_at(r-1, c-1) + 2 * px_at(r, c-1) + px_at(r+1, c-1));
            gy = (px_at(r+1, c-1) + 2 * px_at(r+1, c) + px_at(r+1, c+1))
               - (px_at(r-1, c-1) + 2 * px_at(r-1, c) + px_at(r-1, c+1));
            ax  = (gx < 0) ? -gx : gx;
            ay  = (gy < 0) ? -gy : gy;
            mag = (ax + ay > 255) ? 255 : ax + ay;
            case (m)
               0:       v = mag;
               1:       v = (mag >= t) ? 255 : 0;
               2:       v = (ax > 255) ? 255 : ax;
               default: v = (ay > 255) ? 255 : ay;
            endcase
            exp_px.push_back(v);
            exp_last.push_back((r == h - 2) && (c == w - 2));
         end
      end
   endtask

   // Mode/threshold are scrambled right after start to prove they were latched
   task automatic start_frame(input int k, input logic [1:0] m, input logic [7:0] t);
      n_out = 0;
      post_last = 0;
      stalled_prev = 1'b0;
      stall_done = 1'b0;
      mode = m;
      thr = t;
      start[k] = 1'b1;
      @(posedge clk); #1;
      start[k] = 1'b0;
      mode = ~m;
      thr = ~t;
   endtask

   task automatic feed(input int k, input int n, input bit rnd, input int restart_at);
      int idx = 0;
      int cyc = 0;
      bit acc;
      while (idx < n && cyc < 2000) begin
         in_px = 8'(img[idx]);
         in_valid[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start[k] = (cyc == restart_at);
         @(negedge clk);
         acc = in_valid[k] && in_ready[k];
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      in_valid[k] = 1'b0;
      start[k] = 1'b0;
      chk("pixels_accepted", idx, n);
   endtask

   task automatic drain(input int n_exp);
      int cyc = 0;
      while ((exp_px.size() != 0 || post_last != 0) && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("drain_complete", int'(exp_px.size() == 0 && post_last == 0), 1);
      chk("out_count", n_out, n_exp);
   endtask

   // Output-side backpressure: hold ready low 5 cycles on the 2nd output
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) out_ready = 1'b1;
         end else if (stall_mode && !stall_done && n_out == 1 && out_valid[act]) begin
            out_ready  = 1'b0;
            stall_left = 5;
            stall_done = 1'b1;
         end
      end
   end

   // Single compare process against the model queue
   always @(negedge clk) begin
      if (nreset) begin
         if (post_last == 1) begin
            chk("frame_done_pulse", frame_done[act], 1);
            chk("busy_in_done", busy[act], 1);
            post_last = 2;
         end else if (post_last == 2) begin
            chk("frame_done_clear", frame_done[act], 0);
            chk("busy_after_frame", busy[act], 0);
            post_last = 0;
         end
         if (stalled_prev) begin
            chk("stall_valid_hold", out_valid[act], 1);
            chk("stall_px_hold", out_px[act], hold_px);
         end
         stalled_prev = out_valid[act] && !out_ready;
         hold_px = out_px[act];
         if (stalled_prev) chk("stall_in_ready", in_ready[act], 0);
         if (out_valid[act] && out_ready) begin
            if (exp_px.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got px %0d with nothing expected", out_px[act]);
            end else begin
               int ep;
               bit el;
               ep = exp_px.pop_front();
               el = exp_last.pop_front();
               chk("out_px", out_px[act], ep);
               chk("out_last", out_last[act], int'(el));
               if (el) post_last = 1;
            end
            n_out++;
         end
      end
   end

   initial begin
      nreset = 1'b0;
      mode = 2'b00;
      thr = 8'd0;
      in_px = 8'd0;
      for (int k = 0; k < NDUT; k++) begin
         start[k] = 1'b0;
         in_valid[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("rst_in_ready", in_ready[k], 0);
         chk("rst_out_valid", out_valid[k], 0);
         chk("rst_out_px", out_px[k], 0);
         chk("rst_out_last", out_last[k], 0);
         chk("rst_busy", busy[k], 0);
         chk("rst_frame_done", frame_done[k], 0);
      end
      nreset = 1'b1;
      @(posedge clk); #1;

      // Flat 4x4 frame: no edges
      act = 0; w = 4; h = 4;
      for (int i = 0; i < 16; i++) img[i] = 100;
      build_model(0, 0);
      chk("model_flat_count", exp_px.size(), 4);
      chk("model_flat_px", exp_px[0], 0);
      start_frame(0, 2'b00, 8'd0);
      feed(0, 16, 1'b0, -1);
      drain(4);

      // 4x4 hard vertical edge saturates
      for (int i = 0; i < 16; i++) img[i] = ((i % 4) >= 2) ? 255 : 0;
      build_model(0, 0);
      chk("model_edge_px", exp_px[3], 255);
      start_frame(0, 2'b00, 8'd0);
      feed(0, 16, 1'b0, -1);
      drain(4);

      // 5x5 horizontal ramp: |Gx| = 80, |Gy| = 0
      act = 1; w = 5; h = 5;
      for (int i = 0; i < 25; i++) img[i] = (i % 5) * 10;
      build_model(2, 0);
      chk("model_ramp_gx", exp_px[0], 80);
      start_frame(1, 2'b10, 8'd0);
      feed(1, 25, 1'b0, -1);
      drain(9);
      build_model(3, 0);
      chk("model_ramp_gy", exp_px[4], 0);
      start_frame(1, 2'b11, 8'd0);
      feed(1, 25, 1'b0, -1);
      drain(9);

      // 4x4 edge 0/60 thresholded: magnitude 240
      act = 0; w = 4; h = 4;
      for (int i = 0; i < 16; i++) img[i] = ((i % 4) >= 2) ? 60 : 0;
      build_model(1, 200);
      chk("model_thr200", exp_px[0], 255);
      start_frame(0, 2'b01, 8'd200);
      feed(0, 16, 1'b0, -1);
      drain(4);
      build_model(1, 250);
      chk("model_thr250", exp_px[0], 0);
      start_frame(0, 2'b01, 8'd250);
      feed(0, 16, 1'b0, -1);
      drain(4);

      // 6x6 random frame with bursty input and an output stall
      act = 2; w = 6; h = 6;
      for (int i = 0; i < 36; i++) img[i] = int'($urandom_range(0, 255));
      build_model(0, 0);
      chk("model_rand_count", exp_px.size(), 16);
      stall_mode = 1'b1;
      start_frame(2, 2'b00, 8'd0);
      feed(2, 36, 1'b1, -1);
      drain(16);
      chk("stall_seen", int'(stall_done), 1);
      stall_mode = 1'b0;

      // Reset mid-frame, then a clean constant frame with a stray start in RUN
      exp_px.delete();
      exp_last.delete();
      for (int i = 0; i < 36; i++) img[i] = 50;
      start_frame(2, 2'b00, 8'd0);
      feed(2, 7, 1'b0, -1);
      #2;
      nreset = 1'b0;
      #1;
      chk("midrst_busy", busy[2], 0);
      chk("midrst_in_ready", in_ready[2], 0);
      chk("midrst_out_valid", out_valid[2], 0);
      chk("midrst_frame_done", frame_done[2], 0);
      @(posedge clk); #1;
      nreset = 1'b1;
      stalled_prev = 1'b0;
      post_last = 0;
      @(posedge clk); #1;
      build_model(0, 0);
      start_frame(2, 2'b00, 8'd0);
      feed(2, 36, 1'b0, 10);
      drain(16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
